// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Consumed by aes128_round and aes128_encrypt_iter.
package aes128_pkg;

  localparam int NR       = 10;
  localparam int KEY_W    = 128;
  localparam int RK_BUS_W = 1408;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } aes_state_e;

  // Forward S-box, row-major: entry x sits at byte (255 - x) of the vector.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round.sv
// One AES round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
// With AES128_SBOX_PIPE_EN defined, a register splits SubBytes+ShiftRows from the rest.
module aes128_round
  import aes128_pkg::*;
(
`ifdef AES128_SBOX_PIPE_EN
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pipe_en,
`endif
  input  logic [KEY_W-1:0] i_state,
  input  logic             i_final,
  input  logic [KEY_W-1:0] i_round_key,
  output logic [KEY_W-1:0] o_state
);

  logic [KEY_W-1:0] sr_flat;
  logic [KEY_W-1:0] mix_in;
  logic [KEY_W-1:0] mixed;

  // Byte i = 4*col + row, byte 0 in the MSBs.
  always_comb begin
    sr_flat = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_flat[127 - 8*(4*c + r) -: 8] = sbox(i_state[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
  end

`ifdef AES128_SBOX_PIPE_EN
  logic [KEY_W-1:0] sr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q <= '0;
    end else if (i_pipe_en) begin
      sr_q <= sr_flat;
    end
  end

  assign mix_in = sr_q;
`else
  assign mix_in = sr_flat;
`endif

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mixed[127 - 8*(4*c + r) -: 8] =
            xtime(mix_in[127 - 8*(4*c + r) -: 8])
          ^ xtime(mix_in[127 - 8*(4*c + (r + 1) % 4) -: 8])
          ^ mix_in[127 - 8*(4*c + (r + 1) % 4) -: 8]
          ^ mix_in[127 - 8*(4*c + (r + 2) % 4) -: 8]
          ^ mix_in[127 - 8*(4*c + (r + 3) % 4) -: 8];
      end
    end
  end

  assign o_state = (i_final ? mix_in : mixed) ^ i_round_key;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per cycle, or per two cycles with AES128_SBOX_PIPE_EN.
// Round keys are read live from i_round_key and must stay stable until o_done.
module aes128_encrypt_iter
  import aes128_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [KEY_W-1:0]    i_plaintext,
  input  logic [RK_BUS_W-1:0] i_round_key,
  output logic [KEY_W-1:0]    o_ciphertext,
  output logic                o_busy,
  output logic                o_done
);

  aes_state_e       fsm_q, fsm_d;
  logic [3:0]       round_q;
  logic [KEY_W-1:0] state_q;
  logic [KEY_W-1:0] round_out;
  logic [KEY_W-1:0] rk_sel;
  logic [3:0]       rk_idx;
  logic [10:0]      rk_lsb;
  logic             commit;

  assign rk_idx = 4'(NR) - round_q;
  assign rk_lsb = {rk_idx, 7'b0};
  assign rk_sel = i_round_key[rk_lsb +: KEY_W];

`ifdef AES128_SBOX_PIPE_EN
  logic phase_q;

  // Phase 0 fills the S-box register, phase 1 commits the round.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= (fsm_q != IDLE) && !phase_q;
    end
  end

  assign commit = phase_q;

  aes128_round u_round (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pipe_en   ((fsm_q != IDLE) && !phase_q),
    .i_state     (state_q),
    .i_final     (fsm_q == FINAL),
    .i_round_key (rk_sel),
    .o_state     (round_out)
  );
`else
  assign commit = 1'b1;

  aes128_round u_round (
    .i_state     (state_q),
    .i_final     (fsm_q == FINAL),
    .i_round_key (rk_sel),
    .o_state     (round_out)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (i_start) fsm_d = ROUND;
      ROUND:   if (commit && round_q == 4'(NR - 1)) fsm_d = FINAL;
      FINAL:   if (commit) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= '0;
      round_q      <= '0;
      o_ciphertext <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (i_start) begin
            state_q <= i_plaintext ^ i_round_key[RK_BUS_W-1 -: KEY_W];
            round_q <= 4'd1;
          end
        end
        ROUND: begin
          if (commit) begin
            state_q <= round_out;
            round_q <= round_q + 4'd1;
          end
        end
        FINAL: begin
          if (commit) begin
            o_ciphertext <= round_out;
            o_done       <= 1'b1;
            round_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter against a byte-level AES model
// whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes128_encrypt_iter;

`ifdef AES128_SBOX_PIPE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 10;
`endif
  localparam int P = LAT + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [127:0]   plaintext;
  logic [1407:0]  round_key;
  logic [127:0]   ciphertext;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_t [256];

  aes128_encrypt_iter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_plaintext  (plaintext),
    .i_round_key  (round_key),
    .o_ciphertext (ciphertext),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] bus;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]] ^ rc, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) bus[1407 - 32*i -: 32] = w[i];
    return bus;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1407:0] rk);
    logic [7:0] s  [16];
    logic [7:0] t  [16];
    logic [7:0] u  [16];
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] res;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[1407 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          u[4*c + row] = t[4*((c + row) % 4) + row];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          if (r == 10) begin
            acc = u[4*c + row];
          end else begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row + 4) % 4], u[4*c + j]);
          end
          s[4*c + row] = acc ^ rk[128*(10 - r) + 127 - 8*(4*c + row) -: 8];
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenarios ----------------
  task automatic run_one(input logic [127:0] pt, input logic [1407:0] rk,
                         input logic [127:0] exp_ct, input string nm);
    @(negedge clk);
    start = 1'b1;
    plaintext = pt;
    round_key = rk;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        plaintext = ~pt;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done cycle %0d: busy=%b done=%b, required busy=1 done=0", nm, k, busy, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse: done=%b busy=%b, required done=1 busy=0", nm, done, busy);
    end
    checks++;
    if (ciphertext !== exp_ct) begin
      errors++;
      $display("FAIL %s ciphertext: got %h, required %h", nm, ciphertext, exp_ct);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ciphertext !== exp_ct) begin
      errors++;
      $display("FAIL %s after done: done=%b ct=%h, required done=0 ct=%h", nm, done, ciphertext, exp_ct);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    plaintext = '0;
    round_key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ciphertext !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset state: ct=%h done=%b busy=%b, required all 0", ciphertext, done, busy);
    end
  endtask

  task automatic test_fips_c1();
    run_one(128'h00112233445566778899aabbccddeeff, expand(128'h000102030405060708090a0b0c0d0e0f),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
  endtask

  task automatic test_fips_b();
    run_one(128'h3243f6a8885a308d313198a2e0370734, expand(128'h2b7e151628aed2a6abf7158809cf4f3c),
            128'h3925841d02dc09fbdc118597196a0b32, "fips_b");
  endtask

  task automatic test_random();
    logic [127:0]  k;
    logic [127:0]  pt;
    logic [1407:0] rk;
    for (int n = 0; n < 6; n++) begin
      k  = rand128();
      pt = (n == 0) ? 128'h0 : (n == 1) ? '1 : rand128();
      rk = expand(k);
      run_one(pt, rk, aes_ref(pt, rk), "random");
    end
  endtask

  task automatic test_start_held();
    logic [127:0]  pt;
    logic [1407:0] rk;
    logic [127:0]  exp_ct;
    logic          exp_done;
    int            n_done;
    int            n_exp;
    pt = rand128();
    rk = expand(rand128());
    exp_ct = aes_ref(pt, rk);
    n_done = 0;
    n_exp = 0;
    @(negedge clk);
    start = 1'b1;
    plaintext = pt;
    round_key = rk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_done = (i >= LAT) && ((i - LAT) % P == 0);
      if (exp_done) n_exp++;
      if (done === 1'b1) n_done++;
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL start_held done at edge %0d: got %b, required %b", i, done, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (ciphertext !== exp_ct) begin
          errors++;
          $display("FAIL start_held ciphertext edge %0d: got %h, required %h", i, ciphertext, exp_ct);
        end
      end
    end
    checks++;
    if (n_done != n_exp) begin
      errors++;
      $display("FAIL start_held pulse count: got %0d, required %0d", n_done, n_exp);
    end
    start = 1'b0;
    for (int i = 0; i < 3 * P && (busy !== 1'b0 || done !== 1'b0); i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ciphertext !== exp_ct) begin
      errors++;
      $display("FAIL start_held drain: busy=%b ct=%h, required busy=0 ct=%h", busy, ciphertext, exp_ct);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0]  pt;
    logic [1407:0] rk;
    int            stray;
    pt = rand128();
    rk = expand(rand128());
    @(negedge clk);
    start = 1'b1;
    plaintext = pt;
    round_key = rk;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid state: busy=%b done=%b ct=%h, required 0/0/0", busy, done, ciphertext);
    end
    stray = 0;
    for (int i = 0; i < P + 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid quiet: %0d cycles with done/busy high, required 0", stray);
    end
    run_one(pt, rk, aes_ref(pt, rk), "after_reset");
  endtask

  task automatic test_hold();
    logic [127:0]  pt;
    logic [1407:0] rk;
    logic [127:0]  exp_ct;
    int            stray;
    pt = rand128();
    rk = expand(rand128());
    exp_ct = aes_ref(pt, rk);
    run_one(pt, rk, exp_ct, "hold_setup");
    stray = 0;
    for (int i = 0; i < P + 4; i++) begin
      @(negedge clk);
      plaintext = rand128();
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (ciphertext !== exp_ct || stray != 0) begin
      errors++;
      $display("FAIL hold: ct=%h stray=%0d, required ct=%h stray=0", ciphertext, stray, exp_ct);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    plaintext = '0;
    round_key = '0;
    init_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_random();
    test_start_held();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes128_encrypt_iter.md
# aes128_encrypt_iter

Iterative AES-128 encryption datapath that consumes the 11 round keys produced by the key schedule and encrypts one 128-bit block per start request. It sits directly downstream of the key-schedule block and takes its flattened round-key bus unchanged. It applies one AES round per cycle, or per two cycles when pipelined, and presents the ciphertext with a one-cycle done pulse.

## Interface
- No parameters. Round count and key size are fixed constants in the shared package.
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_plaintext  in  128  input block; byte 0 = bits [127:120], column-major per FIPS-197
- i_round_key  in  1408  round keys; round r key = bits [128*(10-r)+127 : 128*(10-r)], so round 0 = [1407:1280] and round 10 = [127:0]
- o_ciphertext  out  128  result register; holds last result until next completion
- o_busy  out  1  high while an encryption is in flight
- o_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ROUND, FINAL.
- IDLE, i_start=1: state_reg <= i_plaintext ^ rk0; round <= 1; go to ROUND. i_plaintext is captured at this edge only.
- ROUND: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk[round]; round <= round+1. When round==9, go to FINAL.
- FINAL: o_ciphertext <= ShiftRows(SubBytes(state_reg)) ^ rk10; o_done <= 1; go to IDLE.
- i_round_key is not latched. The upstream stage must hold it stable from the start edge through completion; the key schedule does this after its own done.
- i_start outside IDLE is ignored. It is not queued.
- A start in the cycle where o_done=1 is accepted, because the FSM is already in IDLE.
- Arithmetic: GF(2^8) with polynomial 0x11B. xtime = shift left 1, then XOR 0x1B on carry-out. Round counter is 4 bits, range 0..10, never wraps.

## Timing
- Reset values: o_ciphertext=0, o_done=0, o_busy=0, FSM=IDLE, round=0. A reset mid-operation aborts the encryption, and no done pulse is produced.
- Latency, default build: start sampled at edge E0, rounds 1..9 at E1..E9, final round at E10. o_done=1 and o_ciphertext valid in the cycle after E10. o_done returns to 0 at E11.
- Throughput, default build: one block per 11 cycles when starts are issued back-to-back on the o_done cycle.
- o_busy=1 from the cycle after E0 through the cycle before o_done rises. It is 0 in IDLE.
- o_done and o_ciphertext update on the same edge.

## Configuration
- AES128_SBOX_PIPE_EN defined: a register is inserted after SubBytes+ShiftRows, so each round takes 2 cycles. E0 loads; each of rounds 1..10 takes two edges; o_done is high in the cycle after E20. o_busy covers the longer span. The handshake is otherwise unchanged.
- AES128_SBOX_PIPE_EN undefined: single-cycle rounds as described in Operation and Timing.

## Structure
- Shared package aes128_pkg:
  - constants NR=10, KEY_W=128, RK_BUS_W=1408
  - FSM state encoding
  - S-box function, xtime function
- Sub-module aes128_round: combinational SubBytes/ShiftRows/optional MixColumns/AddRoundKey.
  - A final-round input bypasses MixColumns.
  - It is the split point for the AES128_SBOX_PIPE_EN register.
- Round-key slice selection is a mux indexed by `10 - round` inside the top module.

## Test plan
- FIPS-197 C.1: key 000102…0f expanded upstream, plaintext 00112233445566778899aabbccddeeff -> o_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, o_done single pulse in the cycle after E10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Start held high continuously for 40 cycles with fixed inputs -> exactly one encryption per 11 cycles, each with the correct ciphertext; mid-run starts are ignored.
- Reset asserted at E5 -> o_busy=0 and o_done=0 next cycle, o_ciphertext=0, no done pulse. A following start produces the correct result.
- After completion, i_plaintext is changed with no start -> o_ciphertext holds the prior value.
- With AES128_SBOX_PIPE_EN defined, C.1 vector -> same ciphertext, o_done in the cycle after E20.
